// File: rtl/mlp_train_sequencer.sv
// Training sequencer for the MLP core: per epoch/sample it copies the input vector from
// SRAM into the x RAM, then runs feedforward and backprop, owning and muxing the SRAM bus.
module mlp_train_sequencer #(
    parameter int          N_IN        = 64,
    parameter int          N_SAMPLE    = 16,
    parameter int          N_EPOCH     = 8,
    parameter logic [16:0] ADDR_X_BASE = 17'h10000,
    parameter int          X_AW        = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [7:0]      epoch_cnt,
    output logic [7:0]      sample_cnt,
    input  logic [7:0]      sram_read_data,
    output logic [16:0]     sram_addr,
    output logic [7:0]      sram_write_data,
    output logic            sram_data_output_en,
    output logic            sram_cs_n,
    output logic            sram_we_n,
    output logic            sram_oe_n,
    output logic            ff_reset,
    output logic            ff_run,
    input  logic            ff_fin,
    input  logic [16:0]     ff_sram_addr,
    input  logic [7:0]      ff_sram_write_data,
    input  logic            ff_sram_data_output_en,
    input  logic            ff_sram_cs_n,
    input  logic            ff_sram_we_n,
    input  logic            ff_sram_oe_n,
    output logic            bp_reset,
    output logic            bp_run,
    input  logic            bp_fin,
    input  logic [16:0]     bp_sram_addr,
    input  logic [7:0]      bp_sram_write_data,
    input  logic            bp_sram_data_output_en,
    input  logic            bp_sram_cs_n,
    input  logic            bp_sram_we_n,
    input  logic            bp_sram_oe_n,
    output logic            x_we,
    output logic [X_AW-1:0] x_waddr,
    output logic [7:0]      x_d
);

    typedef enum logic [2:0] {
        S_IDLE, S_LX_ADDR, S_LX_WR, S_FF_RST, S_FF_RUN, S_BP_RST, S_BP_RUN, S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [7:0]        epoch_q, epoch_d, sample_q, sample_d;
    logic [X_AW-1:0]   elem_q, elem_d;
    logic              ff_reset_q, ff_reset_d, ff_run_q, ff_run_d;
    logic              bp_reset_q, bp_reset_d, bp_run_q, bp_run_d;
    logic              x_we_q, x_we_d;
    logic [X_AW-1:0]   x_waddr_q, x_waddr_d;
    logic [7:0]        x_d_q, x_d_d;
    logic [16:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              doe_q, doe_d, cs_n_q, cs_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            epoch_q    <= '0;
            sample_q   <= '0;
            elem_q     <= '0;
            ff_reset_q <= 1'b1;
            ff_run_q   <= 1'b0;
            bp_reset_q <= 1'b1;
            bp_run_q   <= 1'b0;
            x_we_q     <= 1'b0;
            x_waddr_q  <= '0;
            x_d_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            doe_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            epoch_q    <= epoch_d;
            sample_q   <= sample_d;
            elem_q     <= elem_d;
            ff_reset_q <= ff_reset_d;
            ff_run_q   <= ff_run_d;
            bp_reset_q <= bp_reset_d;
            bp_run_q   <= bp_run_d;
            x_we_q     <= x_we_d;
            x_waddr_q  <= x_waddr_d;
            x_d_q      <= x_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            doe_q      <= doe_d;
            cs_n_q     <= cs_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        epoch_d    = epoch_q;
        sample_d   = sample_q;
        elem_d     = elem_q;
        ff_reset_d = ff_reset_q;
        ff_run_d   = ff_run_q;
        bp_reset_d = bp_reset_q;
        bp_run_d   = bp_run_q;
        x_we_d     = x_we_q;
        x_waddr_d  = x_waddr_q;
        x_d_d      = x_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        doe_d      = doe_q;
        cs_n_d     = cs_n_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;

        unique case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d  = S_LX_ADDR;
                busy_d   = 1'b1;
                epoch_d  = '0;
                sample_d = '0;
                elem_d   = '0;
            end
            S_LX_ADDR: begin
                cs_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                we_n_d  = 1'b1;
                addr_d  = ADDR_X_BASE + 17'(32'(sample_q) * N_IN) + 17'(elem_q);
                x_we_d  = 1'b0;
                state_d = S_LX_WR;
            end
            S_LX_WR: begin
                x_d_d     = sram_read_data;
                x_waddr_d = elem_q;
                x_we_d    = 1'b1;
                if (elem_q == X_AW'(N_IN - 1)) begin
                    elem_d  = '0;
                    state_d = S_FF_RST;
                end else begin
                    elem_d  = elem_q + X_AW'(1);
                    state_d = S_LX_ADDR;
                end
            end
            S_FF_RST: begin
                x_we_d     = 1'b0;
                cs_n_d     = 1'b1;
                oe_n_d     = 1'b1;
                ff_reset_d = 1'b1;
                ff_run_d   = 1'b0;
                state_d    = S_FF_RUN;
            end
            S_FF_RUN: if (ff_fin) begin
                ff_run_d   = 1'b0;
                ff_reset_d = 1'b1;
                state_d    = S_BP_RST;
            end else begin
                ff_reset_d = 1'b0;
                ff_run_d   = 1'b1;
            end
            S_BP_RST: begin
                bp_reset_d = 1'b1;
                bp_run_d   = 1'b0;
                state_d    = S_BP_RUN;
            end
            S_BP_RUN: if (bp_fin) begin
                bp_run_d   = 1'b0;
                bp_reset_d = 1'b1;
                state_d    = S_NEXT;
            end else begin
                bp_reset_d = 1'b0;
                bp_run_d   = 1'b1;
            end
            S_NEXT: if (sample_q < 8'(N_SAMPLE - 1)) begin
                sample_d = sample_q + 8'd1;
                state_d  = S_LX_ADDR;
            end else begin
                sample_d = '0;
                if (epoch_q < 8'(N_EPOCH - 1)) begin
                    epoch_d = epoch_q + 8'd1;
                    state_d = S_LX_ADDR;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over whatever the state chose; counters keep their last values.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            ff_run_d   = 1'b0;
            bp_run_d   = 1'b0;
            ff_reset_d = 1'b1;
            bp_reset_d = 1'b1;
            x_we_d     = 1'b0;
            doe_d      = 1'b0;
            cs_n_d     = 1'b1;
            we_n_d     = 1'b1;
            oe_n_d     = 1'b1;
        end
    end

    // Bus ownership follows the state directly so an engine sees its grant the same cycle.
    always_comb begin
        sram_addr           = addr_q;
        sram_write_data     = wdata_q;
        sram_data_output_en = doe_q;
        sram_cs_n           = cs_n_q;
        sram_we_n           = we_n_q;
        sram_oe_n           = oe_n_q;
        if (state_q == S_FF_RUN) begin
            sram_addr           = ff_sram_addr;
            sram_write_data     = ff_sram_write_data;
            sram_data_output_en = ff_sram_data_output_en;
            sram_cs_n           = ff_sram_cs_n;
            sram_we_n           = ff_sram_we_n;
            sram_oe_n           = ff_sram_oe_n;
        end else if (state_q == S_BP_RUN) begin
            sram_addr           = bp_sram_addr;
            sram_write_data     = bp_sram_write_data;
            sram_data_output_en = bp_sram_data_output_en;
            sram_cs_n           = bp_sram_cs_n;
            sram_we_n           = bp_sram_we_n;
            sram_oe_n           = bp_sram_oe_n;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign epoch_cnt  = epoch_q;
    assign sample_cnt = sample_q;
    assign ff_reset   = ff_reset_q;
    assign ff_run     = ff_run_q;
    assign bp_reset   = bp_reset_q;
    assign bp_run     = bp_run_q;
    assign x_we       = x_we_q;
    assign x_waddr    = x_waddr_q;
    assign x_d        = x_d_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer: small SRAM model, sticky-fin engine models,
// a per-sample vector table for a full run, then abort/reset/start corner sequences.
module tb_mlp_train_sequencer;

    localparam int N_IN = 4, N_SAMPLE = 2, N_EPOCH = 2;
    localparam int W_XWE = 0, W_FF = 1, W_BP = 2, W_S1 = 3;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic        busy, done, ff_reset, ff_run, bp_reset, bp_run, x_we;
    logic [7:0]  epoch_cnt, sample_cnt, sram_read_data, sram_write_data, x_d;
    logic [16:0] sram_addr;
    logic        sram_data_output_en, sram_cs_n, sram_we_n, sram_oe_n;
    logic        ff_fin, bp_fin;
    logic [16:0] ff_sram_addr = '0, bp_sram_addr = '0;
    logic [9:0]  x_waddr;

    logic [7:0]  mem [8];
    logic        ff_fin_m = 1'b0, bp_fin_m = 1'b0, ff_fin_force = 1'b0;
    int          ff_cnt = 0, bp_cnt = 0;

    typedef struct {
        logic [7:0]  epoch;
        logic [7:0]  sample;
        logic [16:0] base;
        logic [7:0]  d0;
        logic [16:0] ff_addr;
        logic [16:0] bp_addr;
    } vec_t;
    vec_t vecs[4];

    int          tests = 0, fails = 0, done_seen = 0, n;
    logic [16:0] last_addr = '0;

    always #5 clk = ~clk;

    mlp_train_sequencer #(.N_IN(N_IN), .N_SAMPLE(N_SAMPLE), .N_EPOCH(N_EPOCH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .epoch_cnt(epoch_cnt), .sample_cnt(sample_cnt),
        .sram_read_data(sram_read_data), .sram_addr(sram_addr),
        .sram_write_data(sram_write_data), .sram_data_output_en(sram_data_output_en),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .ff_reset(ff_reset), .ff_run(ff_run), .ff_fin(ff_fin),
        .ff_sram_addr(ff_sram_addr), .ff_sram_write_data(8'hA5),
        .ff_sram_data_output_en(1'b1), .ff_sram_cs_n(1'b0),
        .ff_sram_we_n(1'b0), .ff_sram_oe_n(1'b1),
        .bp_reset(bp_reset), .bp_run(bp_run), .bp_fin(bp_fin),
        .bp_sram_addr(bp_sram_addr), .bp_sram_write_data(8'h5A),
        .bp_sram_data_output_en(1'b1), .bp_sram_cs_n(1'b0),
        .bp_sram_we_n(1'b0), .bp_sram_oe_n(1'b1),
        .x_we(x_we), .x_waddr(x_waddr), .x_d(x_d)
    );

    // Asynchronous-read SRAM holding 0x11..0x18 at 0x10000..0x10007.
    assign sram_read_data = (!sram_cs_n && !sram_oe_n && sram_addr >= 17'h10000 &&
                             sram_addr < 17'h10008) ? mem[sram_addr[2:0]] : 8'h00;

    // Engines raise a sticky fin after five run cycles; only their reset clears it.
    always @(posedge clk) begin
        if (ff_reset) begin ff_cnt <= 0; ff_fin_m <= 1'b0; end
        else if (ff_run) begin if (ff_cnt == 4) ff_fin_m <= 1'b1; else ff_cnt <= ff_cnt + 1; end
        if (bp_reset) begin bp_cnt <= 0; bp_fin_m <= 1'b0; end
        else if (bp_run) begin if (bp_cnt == 4) bp_fin_m <= 1'b1; else bp_cnt <= bp_cnt + 1; end
        if (done) done_seen <= done_seen + 1;
    end
    assign ff_fin = ff_fin_m | ff_fin_force;
    assign bp_fin = bp_fin_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            W_XWE:   return x_we;
            W_FF:    return ff_run;
            W_BP:    return bp_run;
            default: return sample_cnt == 8'd1;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int budget,
                            input string nm, output int cnt);
        cnt = 0;
        while (sig(which) !== val && cnt < budget) begin
            last_addr = sram_addr;
            step();
            cnt++;
        end
        if (sig(which) !== val) check({nm, " timeout"}, 32'(sig(which)), 32'(val));
    endtask

    task automatic check_reset(input string p);
        check({p, " busy"}, 32'(busy), 0);
        check({p, " done"}, 32'(done), 0);
        check({p, " epoch"}, 32'(epoch_cnt), 0);
        check({p, " sample"}, 32'(sample_cnt), 0);
        check({p, " ff_reset/run"}, {30'b0, ff_reset, ff_run}, 32'h2);
        check({p, " bp_reset/run"}, {30'b0, bp_reset, bp_run}, 32'h2);
        check({p, " x_we"}, 32'(x_we), 0);
        check({p, " x_waddr"}, 32'(x_waddr), 0);
        check({p, " x_d"}, 32'(x_d), 0);
        check({p, " sram_addr"}, 32'(sram_addr), 0);
        check({p, " sram_wd/oe"}, {23'b0, sram_write_data, sram_data_output_en}, 0);
        check({p, " cs_n/we_n/oe_n"}, {29'b0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h11 + 8'(i);
        vecs[0] = '{8'd0, 8'd0, 17'h10000, 8'h11, 17'h00123, 17'h00456};
        vecs[1] = '{8'd0, 8'd1, 17'h10004, 8'h15, 17'h00124, 17'h00457};
        vecs[2] = '{8'd1, 8'd0, 17'h10000, 8'h11, 17'h00125, 17'h00458};
        vecs[3] = '{8'd1, 8'd1, 17'h10004, 8'h15, 17'h0abcd, 17'h1fff0};

        step(); step();
        check_reset("reset");
        reset = 1'b0;
        step();

        // Full training run: 2 epochs x 2 samples.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ff_sram_addr = vecs[i].ff_addr;
            bp_sram_addr = vecs[i].bp_addr;
            for (int e = 0; e < N_IN; e++) begin
                if (e > 0) step();
                wait_sig(W_XWE, 1'b1, 8, $sformatf("v%0d e%0d x_we", i, e), n);
                check($sformatf("v%0d e%0d load addr", i, e), 32'(last_addr), 32'(vecs[i].base + 17'(e)));
                check($sformatf("v%0d e%0d x_waddr", i, e), 32'(x_waddr), e);
                check($sformatf("v%0d e%0d x_d", i, e), 32'(x_d), 32'(vecs[i].d0 + 8'(e)));
                if (e == 0) begin
                    check($sformatf("v%0d epoch", i), 32'(epoch_cnt), 32'(vecs[i].epoch));
                    check($sformatf("v%0d sample", i), 32'(sample_cnt), 32'(vecs[i].sample));
                end
            end
            ff_fin_force = 1'b1;
            step();
            ff_fin_force = 1'b0;
            wait_sig(W_FF, 1'b1, 8, $sformatf("v%0d ff_run rise", i), n);
            check($sformatf("v%0d ff_run delay", i), n + 1, 2);
            check($sformatf("v%0d ff bus addr", i), 32'(sram_addr), 32'(vecs[i].ff_addr));
            check($sformatf("v%0d ff bus wd/cs", i), {23'b0, sram_write_data, sram_cs_n}, 32'h14A);
            check($sformatf("v%0d bp_run in ff", i), 32'(bp_run), 0);
            wait_sig(W_FF, 1'b0, 20, $sformatf("v%0d ff_run fall", i), n);
            check($sformatf("v%0d ff_run len", i), n, 6);
            check($sformatf("v%0d ff_reset after fin", i), 32'(ff_reset), 1);
            wait_sig(W_BP, 1'b1, 8, $sformatf("v%0d bp_run rise", i), n);
            check($sformatf("v%0d bp_run delay", i), n, 2);
            check($sformatf("v%0d bp bus addr", i), 32'(sram_addr), 32'(vecs[i].bp_addr));
            check($sformatf("v%0d bp bus wd", i), 32'(sram_write_data), 32'h5A);
            check($sformatf("v%0d ff_run in bp", i), 32'(ff_run), 0);
            wait_sig(W_BP, 1'b0, 20, $sformatf("v%0d bp_run fall", i), n);
            check($sformatf("v%0d bp_run len", i), n, 6);
        end
        step();
        check("done pulse", 32'(done), 1);
        check("busy with done", 32'(busy), 0);
        check("final epoch/sample", {16'b0, epoch_cnt, sample_cnt}, 32'h0100);
        step();
        check("done one cycle", 32'(done), 0);
        check("done count", done_seen, 1);

        // start while busy is ignored; abort in FF_RUN of sample 1.
        start = 1'b1; step(); start = 1'b0;
        wait_sig(W_XWE, 1'b1, 8, "rerun x_we0", n);
        check("rerun waddr0", 32'(x_waddr), 0);
        start = 1'b1; step(); start = 1'b0;
        wait_sig(W_XWE, 1'b1, 8, "busy-start x_we1", n);
        check("busy-start waddr1", 32'(x_waddr), 1);
        check("busy-start busy", 32'(busy), 1);
        wait_sig(W_S1, 1'b1, 200, "reach sample1", n);
        wait_sig(W_FF, 1'b1, 50, "sample1 ff_run", n);
        check("pre-abort ff cs_n", 32'(sram_cs_n), 0);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort ff_run/reset", {30'b0, ff_run, ff_reset}, 32'h1);
        check("abort cs_n", 32'(sram_cs_n), 1);
        check("abort done", 32'(done), 0);
        check("abort counters hold", {16'b0, epoch_cnt, sample_cnt}, 32'h0001);
        repeat (5) step();
        check("abort no done", done_seen, 1);
        check("abort stays idle", {30'b0, busy, ff_run}, 0);

        // Restart after abort begins again from sample 0.
        start = 1'b1; step(); start = 1'b0;
        check("restart busy", 32'(busy), 1);
        check("restart counters", {16'b0, epoch_cnt, sample_cnt}, 0);
        wait_sig(W_XWE, 1'b1, 8, "restart x_we", n);
        check("restart load addr", 32'(last_addr), 32'h10000);
        check("restart x_d", 32'(x_d), 32'h11);

        // Synchronous reset in the middle of a load.
        reset = 1'b1; step();
        check_reset("midlx");
        reset = 1'b0; step();

        // start and abort together in IDLE: nothing happens.
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check("start+abort busy", 32'(busy), 0);
        step(); step();
        check("start+abort bus idle", {30'b0, sram_cs_n, x_we}, 32'h2);
        check("start+abort engines", {30'b0, ff_reset, busy}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
